// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle from the memory stage.
// It writes the GPR file, drives CP0 and TLB command strobes, raises the
// pipeline flush with its redirect PC, and drives the debug trace port.
// All side effects are suppressed while reset is asserted, so an
// instruction caught in WS by a reset never writes anything.
module wb_stage #(
    parameter int          MS_TO_WS_BUS_WD = 162,
    parameter logic [31:0] EXC_ENTRY       = 32'hBFC00380
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic [40:0]                ws_to_rf_bus,
    output logic [9:0]                 stall_ws_bus,
    output logic [32:0]                forward_ws_bus,
    output logic                       flush,
    output logic [31:0]                flush_pc,
    output logic                       cp0_wen,
    output logic [7:0]                 cp0_addr,
    output logic [31:0]                cp0_wdata,
    input  logic [31:0]                cp0_rdata,
    input  logic [31:0]                cp0_epc,
    output logic                       wb_exc,
    output logic [4:0]                 wb_exccode,
    output logic                       wb_bd,
    output logic [31:0]                wb_pc,
    output logic [31:0]                wb_badvaddr,
    output logic                       wb_eret,
    output logic                       tlbr_we,
    output logic                       tlbwi_we,
    output logic                       tlbp_we,
    output logic [31:0]                tlbp_index,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic                       r_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] r_ws_bus;

    logic [31:0] w_tlbp_index;
    logic        w_entryhi_wen;
    logic        w_tlbr;
    logic        w_tlbwi;
    logic        w_tlbp;
    logic [31:0] w_badvaddr;
    logic        w_bd;
    logic        w_exc;
    logic [7:0]  w_exc_type;
    logic        w_eret;
    logic        w_cp0_wen;
    logic        w_res_from_cp0;
    logic [7:0]  w_cp0_addr;
    logic [3:0]  w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_result;
    logic [31:0] w_pc;

    logic        w_live;
    logic        w_commit;
    logic        w_flush;
    logic [3:0]  w_rf_we;
    logic [31:0] w_rf_wdata;
    logic [4:0]  w_exccode;
    logic [31:0] w_flush_pc;

    assign {w_tlbp_index, w_entryhi_wen, w_tlbr, w_tlbwi, w_tlbp,
            w_badvaddr, w_bd, w_exc, w_exc_type, w_eret, w_cp0_wen,
            w_res_from_cp0, w_cp0_addr, w_gr_we, w_dest, w_result, w_pc} = r_ws_bus;

    // WS never stalls.
    assign ws_allowin = 1'b1;

    // A held reset kills the resident instruction in the same cycle.
    assign w_live   = r_ws_valid & ~reset;
    assign w_commit = w_live & ~w_exc;
    assign w_flush  = w_live & (w_exc | w_eret | w_tlbr | w_tlbwi | w_entryhi_wen);

    // Valid bit: cleared by reset or by our own flush, otherwise follows MS.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
        end else if (w_flush) begin
            r_ws_valid <= 1'b0;
        end else begin
            r_ws_valid <= ms_to_ws_valid;
        end
    end

    // Bundle register: only a surviving valid instruction is captured.
    always_ff @(posedge clk) begin
        if (ms_to_ws_valid && !w_flush) begin
            r_ws_bus <= ms_to_ws_bus;
        end
    end

    assign w_rf_we    = {4{w_commit}} & w_gr_we;
    assign w_rf_wdata = w_res_from_cp0 ? cp0_rdata : w_result;

    // ExcCode: the highest set exc_type bit wins; an empty type is reserved.
    always_comb begin
        w_exccode = 5'h1F;
        if (w_exc_type[7]) begin
            w_exccode = 5'h00;
        end else if (w_exc_type[6] || w_exc_type[5]) begin
            w_exccode = 5'h04;
        end else if (w_exc_type[4]) begin
            w_exccode = 5'h05;
        end else if (w_exc_type[3]) begin
            w_exccode = 5'h08;
        end else if (w_exc_type[2]) begin
            w_exccode = 5'h09;
        end else if (w_exc_type[1]) begin
            w_exccode = 5'h0A;
        end else if (w_exc_type[0]) begin
            w_exccode = 5'h0C;
        end
    end

    // Redirect target: exception vector, then EPC, then refetch of pc+4.
    always_comb begin
        w_flush_pc = w_pc + 32'd4;
        if (w_exc) begin
            w_flush_pc = EXC_ENTRY;
        end else if (w_eret) begin
            w_flush_pc = cp0_epc;
        end
    end

    assign ws_to_rf_bus   = {w_rf_we, w_dest, w_rf_wdata};
    assign stall_ws_bus   = {w_live & (|w_gr_we), w_gr_we & {4{w_live}}, w_dest};
    assign forward_ws_bus = {w_live & ~w_exc & (|w_gr_we), w_rf_wdata};

    assign flush    = w_flush;
    assign flush_pc = w_flush_pc;

    assign cp0_wen   = w_commit & w_cp0_wen;
    assign cp0_addr  = w_cp0_addr;
    assign cp0_wdata = w_result;

    assign wb_exc      = w_live & w_exc;
    assign wb_exccode  = w_exccode;
    assign wb_bd       = w_bd;
    assign wb_pc       = w_pc;
    assign wb_badvaddr = w_badvaddr;
    assign wb_eret     = w_commit & w_eret;

    assign tlbr_we    = w_commit & w_tlbr;
    assign tlbwi_we   = w_commit & w_tlbwi;
    assign tlbp_we    = w_commit & w_tlbp;
    assign tlbp_index = w_tlbp_index;

    assign debug_wb_pc       = w_pc;
    assign debug_wb_rf_wen   = w_rf_we;
    assign debug_wb_rf_wnum  = w_dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: each driven instruction pushes its expected
// WS outputs; they are popped and compared one cycle later.
module tb_wb_stage;

    typedef struct packed {
        logic [31:0] tlbp_index;
        logic        entryhi_wen;
        logic        tlbr;
        logic        tlbwi;
        logic        tlbp;
        logic [31:0] badvaddr;
        logic        bd;
        logic        exc;
        logic [7:0]  exc_type;
        logic        eret;
        logic        cp0_wen;
        logic        res_from_cp0;
        logic [7:0]  cp0_addr;
        logic [3:0]  gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        logic        valid;
        logic [3:0]  rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fwd;
        logic        flush;
        logic [31:0] flush_pc;
        logic        cp0_wen;
        logic        exc;
        logic [4:0]  code;
        logic        eret;
        logic        tlbr;
        logic        tlbwi;
        logic        tlbp;
        logic [31:0] pc;
        logic [31:0] badvaddr;
    } exp_t;

    localparam logic [31:0] EXC_ENTRY = 32'hBFC00380;
    localparam logic [31:0] EPC       = 32'hBFC00200;
    localparam logic [4:0]  CODE [8]  = '{5'h0C, 5'h0A, 5'h09, 5'h08, 5'h05, 5'h04, 5'h04, 5'h00};

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_to_ws_valid;
    logic [161:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic [40:0]  ws_to_rf_bus;
    logic [9:0]   stall_ws_bus;
    logic [32:0]  forward_ws_bus;
    logic         flush;
    logic [31:0]  flush_pc;
    logic         cp0_wen;
    logic [7:0]   cp0_addr;
    logic [31:0]  cp0_wdata;
    logic [31:0]  cp0_rdata;
    logic [31:0]  cp0_epc;
    logic         wb_exc;
    logic [4:0]   wb_exccode;
    logic         wb_bd;
    logic [31:0]  wb_pc;
    logic [31:0]  wb_badvaddr;
    logic         wb_eret;
    logic         tlbr_we;
    logic         tlbwi_we;
    logic         tlbp_we;
    logic [31:0]  tlbp_index;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_fn(input logic [7:0] a);
        return (a == 8'h60) ? 32'hDEADBEEF : {24'h5A5A5A, a};
    endfunction

    assign cp0_rdata = rdata_fn(cp0_addr);
    assign cp0_epc   = EPC;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin), .ws_to_rf_bus(ws_to_rf_bus),
        .stall_ws_bus(stall_ws_bus), .forward_ws_bus(forward_ws_bus),
        .flush(flush), .flush_pc(flush_pc),
        .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc),
        .wb_exc(wb_exc), .wb_exccode(wb_exccode), .wb_bd(wb_bd),
        .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .wb_eret(wb_eret),
        .tlbr_we(tlbr_we), .tlbwi_we(tlbwi_we), .tlbp_we(tlbp_we),
        .tlbp_index(tlbp_index),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic v, input ins_t i);
        exp_t e;
        logic commit;
        commit     = v & ~i.exc;
        e.valid    = v;
        e.rf_we    = commit ? i.gr_we : 4'h0;
        e.waddr    = i.dest;
        e.wdata    = i.res_from_cp0 ? rdata_fn(i.cp0_addr) : i.result;
        e.fwd      = v & ~i.exc & (|i.gr_we);
        e.flush    = v & (i.exc | i.eret | i.tlbr | i.tlbwi | i.entryhi_wen);
        e.flush_pc = i.exc ? EXC_ENTRY : (i.eret ? EPC : i.pc + 32'd4);
        e.cp0_wen  = commit & i.cp0_wen;
        e.exc      = v & i.exc;
        e.code     = 5'h1F;
        for (int b = 0; b < 8; b++) begin
            if (i.exc_type[b]) e.code = CODE[b];
        end
        e.eret     = commit & i.eret;
        e.tlbr     = commit & i.tlbr;
        e.tlbwi    = commit & i.tlbwi;
        e.tlbp     = commit & i.tlbp;
        e.pc       = i.pc;
        e.badvaddr = i.badvaddr;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        chk("rf_we", ws_to_rf_bus[40:37], e.rf_we);
        chk("trace_wen", debug_wb_rf_wen, e.rf_we);
        chk("fwd_valid", forward_ws_bus[32], e.fwd);
        chk("stall_valid", stall_ws_bus[9], e.fwd | (e.exc & (|stall_ws_bus[8:5])));
        chk("flush", flush, e.flush);
        chk("cp0_wen", cp0_wen, e.cp0_wen);
        chk("wb_exc", wb_exc, e.exc);
        chk("wb_eret", wb_eret, e.eret);
        chk("tlbr_we", tlbr_we, e.tlbr);
        chk("tlbwi_we", tlbwi_we, e.tlbwi);
        chk("tlbp_we", tlbp_we, e.tlbp);
        if (e.valid) begin
            chk("waddr", ws_to_rf_bus[36:32], e.waddr);
            chk("wdata", ws_to_rf_bus[31:0], e.wdata);
            chk("fwd_data", forward_ws_bus[31:0], e.wdata);
            chk("trace_pc", debug_wb_pc, e.pc);
            chk("trace_wdata", debug_wb_rf_wdata, e.wdata);
        end
        if (e.flush) chk("flush_pc", flush_pc, e.flush_pc);
        if (e.exc) begin
            chk("exccode", wb_exccode, e.code);
            chk("wb_pc", wb_pc, e.pc);
            chk("badvaddr", wb_badvaddr, e.badvaddr);
        end
    endtask

    // One cycle: check what WS shows now, then offer the next instruction.
    task automatic step(input logic v, input ins_t ins);
        exp_t e;
        logic fl;
        fl = 1'b0;
        @(negedge clk);
        if (q.size() > 0) begin
            e  = q.pop_front();
            compare(e);
            fl = e.flush;
        end
        ms_to_ws_valid = v;
        ms_to_ws_bus   = ins;
        q.push_back(model(v & ~fl, ins));
    endtask

    ins_t i;
    ins_t z;

    initial begin
        z = '0;
        reset = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flush", flush, 0);
        chk("rst_rf_we", ws_to_rf_bus[40:37], 0);
        chk("rst_cp0_wen", cp0_wen, 0);
        chk("rst_wb_exc", wb_exc, 0);
        chk("rst_wb_eret", wb_eret, 0);
        chk("rst_tlb", {tlbr_we, tlbwi_we, tlbp_we}, 0);
        chk("allowin", ws_allowin, 1);
        reset = 1'b0;
        q.push_back(model(1'b0, z));

        // ADDU
        i = z; i.pc = 32'hBFC00000; i.result = 32'h12345678; i.dest = 5'd5; i.gr_we = 4'hF;
        step(1'b1, i);
        // Load with fetch/load AdEL
        i = z; i.pc = 32'hBFC00100; i.exc = 1'b1; i.exc_type = 8'h20; i.badvaddr = 32'h80000003;
        i.gr_we = 4'hF; i.dest = 5'd3;
        step(1'b1, i);
        step(1'b0, z);
        // MFC0
        i = z; i.pc = 32'hBFC00104; i.res_from_cp0 = 1'b1; i.cp0_addr = 8'h60; i.dest = 5'd8;
        i.gr_we = 4'hF; i.result = 32'h11111111;
        step(1'b1, i);
        // ERET followed by an instruction that must be dropped
        i = z; i.pc = 32'hBFC00108; i.eret = 1'b1;
        step(1'b1, i);
        i = z; i.pc = 32'hBFC0010C; i.result = 32'hCAFE0001; i.dest = 5'd9; i.gr_we = 4'hF;
        step(1'b1, i);
        // TLBWI, then TLBP
        i = z; i.pc = 32'h80001000; i.tlbwi = 1'b1;
        step(1'b1, i);
        step(1'b0, z);
        i = z; i.pc = 32'h80001004; i.tlbp = 1'b1; i.tlbp_index = 32'h80000000;
        step(1'b1, i);
        // TLBR at the top of the address space wraps the refetch PC
        i = z; i.pc = 32'hFFFFFFFC; i.tlbr = 1'b1;
        step(1'b1, i);
        step(1'b0, z);
        // ERET together with an exception: exception wins
        i = z; i.pc = 32'h80002000; i.eret = 1'b1; i.exc = 1'b1; i.exc_type = 8'h08;
        step(1'b1, i);
        step(1'b0, z);
        // Byte-enable write, MTC0
        i = z; i.pc = 32'h80002004; i.gr_we = 4'b0101; i.dest = 5'd31; i.result = 32'hA5A5A5A5;
        step(1'b1, i);
        i = z; i.pc = 32'h80002008; i.cp0_wen = 1'b1; i.cp0_addr = 8'h70; i.result = 32'h00000042;
        step(1'b1, i);

        // Reset while an MTC0 with a register write sits in WS
        i = z; i.pc = 32'h80003000; i.cp0_wen = 1'b1; i.cp0_addr = 8'h60; i.gr_we = 4'hF; i.dest = 5'd4;
        step(1'b1, i);
        @(negedge clk);
        q.delete();
        reset = 1'b1;
        #1;
        chk("rstmid_cp0_wen", cp0_wen, 0);
        chk("rstmid_rf_we", ws_to_rf_bus[40:37], 0);
        chk("rstmid_flush", flush, 0);
        i = z; i.pc = 32'h80003004; i.gr_we = 4'hF; i.dest = 5'd6; i.result = 32'h1;
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus = i;
        @(negedge clk);
        chk("rstafter_rf_we", ws_to_rf_bus[40:37], 0);
        chk("rstafter_valid", stall_ws_bus[9], 0);
        chk("rstafter_cp0_wen", cp0_wen, 0);
        reset = 1'b0;
        ms_to_ws_valid = 1'b0;
        q.push_back(model(1'b0, z));

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            i.tlbp_index   = $urandom;
            i.entryhi_wen  = ($urandom_range(0, 11) == 0);
            i.tlbr         = ($urandom_range(0, 11) == 0);
            i.tlbwi        = ($urandom_range(0, 11) == 0);
            i.tlbp         = ($urandom_range(0, 7) == 0);
            i.badvaddr     = $urandom;
            i.bd           = 1'($urandom_range(0, 1));
            i.exc          = ($urandom_range(0, 4) == 0);
            i.exc_type     = 8'($urandom);
            i.eret         = ($urandom_range(0, 9) == 0);
            i.cp0_wen      = ($urandom_range(0, 5) == 0);
            i.res_from_cp0 = ($urandom_range(0, 4) == 0);
            i.cp0_addr     = ($urandom_range(0, 1) == 0) ? 8'h60 : 8'($urandom);
            i.gr_we        = 4'($urandom);
            i.dest         = 5'($urandom);
            i.result       = $urandom;
            i.pc           = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            step($urandom_range(0, 3) != 0, i);
        end
        step(1'b0, z);
        step(1'b0, z);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage. Accepts the memory-stage bundle and retires one instruction per cycle.
- Writes the GPR file with byte enables and reads/writes CP0.
- Issues TLBR/TLBWI/TLBP commands.
- Raises the single pipeline flush, with its redirect PC, for exceptions, ERET and TLB-state refetch.
- Drives the debug trace port.

Parameters:
- MS_TO_WS_BUS_WD, 162, memory-to-writeback bus width.
- EXC_ENTRY, 32'hBFC00380, general exception vector.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ms_to_ws_valid  in  1  memory stage holds a valid instruction
- ms_to_ws_bus  in  162  fields by bit range:
  - [161:130] tlbp_index
  - [129] entryhi_wen
  - [128] tlbr
  - [127] tlbwi
  - [126] tlbp
  - [125:94] badvaddr
  - [93] bd
  - [92] exc
  - [91:84] exc_type
  - [83] eret
  - [82] cp0_wen
  - [81] res_from_cp0
  - [80:73] cp0_addr {rd,sel}
  - [72:69] gr_we
  - [68:64] dest
  - [63:32] result
  - [31:0] pc
- ws_allowin  out  1  stage can accept
- ws_to_rf_bus  out  41  {rf_we[3:0], rf_waddr[4:0], rf_wdata[31:0]}
- stall_ws_bus  out  10  {ws_valid&gr_we_any, gr_we&{4{ws_valid}}, dest}
- forward_ws_bus  out  33  {fwd_valid, rf_wdata}
- flush  out  1  kill all younger stages
- flush_pc  out  32  refetch/redirect target
- cp0_wen  out  1  CP0 write strobe
- cp0_addr  out  8  CP0 {rd,sel}
- cp0_wdata  out  32  CP0 write data
- cp0_rdata  in  32  CP0 read data (combinational on cp0_addr)
- cp0_epc  in  32  current EPC
- wb_exc  out  1  commit exception
- wb_exccode  out  5  ExcCode
- wb_bd  out  1  branch-delay flag
- wb_pc  out  32  faulting PC
- wb_badvaddr  out  32  BadVAddr value
- wb_eret  out  1  commit ERET
- tlbr_we, tlbwi_we, tlbp_we  out  1 each  TLB commands
- tlbp_index  out  32  Index write value
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte enables
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace data

Behaviour:
- ws_ready_go=1 always; ws_allowin=1 always. ws_valid and bus register ws_bus_r.
- Register update:
  - reset → ws_valid=0.
  - else flush → ws_valid=0 (the incoming instruction is dropped; MS is flushed in the same edge).
  - else ws_valid ← ms_to_ws_valid.
  - ws_bus_r loads when ms_to_ws_valid && !flush; otherwise holds.
- Commit condition: commit = ws_valid && !exc. All side-effect strobes are gated by commit:
  - rf_we = {4{commit}} & gr_we.
  - cp0_wen = commit & cp0_wen_field.
  - tlbr_we / tlbwi_we / tlbp_we = commit & respective field.
  - wb_eret = commit & eret.
- rf_wdata = res_from_cp0 ? cp0_rdata : result. rf_waddr = dest. cp0_wdata = result. cp0_addr = field.
- forward_ws_bus.fwd_valid = ws_valid & !exc & (|gr_we). CP0 reads forward in WS, because cp0_rdata is available here.
- exc_type mapping: one-hot, highest bit wins.
  - [7] Int → 0x00
  - [6] AdEL fetch → 0x04
  - [5] AdEL load → 0x04
  - [4] AdES → 0x05
  - [3] Sys → 0x08
  - [2] Bp → 0x09
  - [1] RI → 0x0A
  - [0] Ov → 0x0C
  - exc=1 with exc_type=0 → 0x1F (reserved; bench error).
- wb_exc = ws_valid & exc. wb_bd / wb_pc / wb_badvaddr pass through from the bus.
- flush = ws_valid & (exc | eret | tlbr | tlbwi | entryhi_wen). Asserted for exactly the one cycle the instruction sits in WS.
- flush_pc priority:
  1. exc → EXC_ENTRY
  2. eret → cp0_epc
  3. TLB/EntryHi refetch → pc+4 (32-bit wrap, 32'hFFFFFFFC+4 = 0)
- eret together with exc: the exception wins; no eret commit.
- debug_wb_pc = pc. debug_wb_rf_wen = rf_we. debug_wb_rf_wnum = dest. debug_wb_rf_wdata = rf_wdata.
- Reset values: all strobes, flush, wb_exc, wb_eret and rf_we are 0. Data outputs are don't-care but must be X-free after the first valid load.
- Reset mid-operation: the in-flight instruction is discarded with no RF/CP0/TLB write in the reset cycle or after.

Test Plan:
- ADDU result 32'h1234_5678, dest=5, gr_we=4'hF → one cycle later rf_we=F, waddr=5, wdata=12345678; forward valid; flush=0.
- Load with exc_type=8'h20, badvaddr=32'h8000_0003, pc=32'hBFC0_0100 → wb_exc=1, exccode=0x04, rf_we=0, flush=1, flush_pc=BFC00380.
- MFC0 rdata=32'hDEAD_BEEF, res_from_cp0=1, dest=8 → wdata=DEADBEEF, cp0_wen=0.
- ERET with cp0_epc=32'hBFC0_0200 → wb_eret=1, flush=1, flush_pc=BFC00200; the ms_to_ws_valid instruction arriving the same cycle never writes.
- TLBWI at pc=32'h8000_1000 → tlbwi_we=1 for one cycle, flush_pc=80001004. TLBP → tlbp_we=1 with no flush.
- reset asserted while a valid SW/MTC0 is in WS → cp0_wen=0 and rf_we=0 that cycle; ws_valid=0 the next cycle.
